// File: rtl/bin_to_7seg_scan.sv
// Binary-to-BCD (sequential double-dabble) with a time-multiplexed 4-digit 7-segment scan driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bin_to_7seg_scan #(
    parameter int REFRESH_DIV = 6750,
    parameter int BIN_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid,
    input  logic [BIN_W-1:0] bin_data,
    output logic             bin_ready,
    output logic [15:0]      bcd_out,
    output logic             overflow,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int ITER_W = $clog2(BIN_W + 1);
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t             state, state_nxt;
    logic               xfer;
    logic [BIN_W-1:0]   shreg;
    logic [15:0]        scratch;
    logic [15:0]        adj;
    logic [ITER_W-1:0]  iter;
    logic               ovf_pend;

    logic [CNT_W-1:0]   cnt;
    logic               cnt_wrap;
    logic [1:0]         idx, idx_nxt;
    logic [3:0]         nib;
    logic [3:0]         lead_zero;
    logic [6:0]         seg_nxt;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'b1000000;
            4'd1:    enc7 = 7'b1111001;
            4'd2:    enc7 = 7'b0100100;
            4'd3:    enc7 = 7'b0110000;
            4'd4:    enc7 = 7'b0011001;
            4'd5:    enc7 = 7'b0010010;
            4'd6:    enc7 = 7'b0000010;
            4'd7:    enc7 = 7'b1111000;
            4'd8:    enc7 = 7'b0000000;
            4'd9:    enc7 = 7'b0010000;
            default: enc7 = 7'b1111111;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        bin_ready = 1'b0;
        xfer      = 1'b0;
        case (state)
            S_IDLE: begin
                bin_ready = 1'b1;
                if (bin_valid) begin
                    xfer      = 1'b1;
                    state_nxt = S_CONV;
                end
            end
            S_CONV:   if (iter == ITER_W'(1)) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Overflow is decided at accept time because the shift register is consumed by the conversion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            scratch  <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else if (xfer) begin
            shreg    <= bin_data;
            scratch  <= '0;
            iter     <= ITER_W'(BIN_W);
            ovf_pend <= 32'(bin_data) > 32'd9999;
        end else if (state == S_CONV) begin
            {scratch, shreg} <= {adj, shreg} << 1;
            iter             <= iter - ITER_W'(1);
        end else if (state == S_COMMIT) begin
            bcd_out  <= scratch;
            overflow <= ovf_pend;
        end
    end

    assign cnt_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_nxt  = cnt_wrap ? idx + 2'd1 : idx;

    // A digit is a leading zero when it and every higher-order digit are zero; units never qualify.
    always_comb begin
        lead_zero[3] = (bcd_out[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd_out[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd_out[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    always_comb begin
        nib = bcd_out[4*idx_nxt +: 4];
        if (overflow) begin
            seg_nxt = 7'b0111111;
        end else begin
            seg_nxt = enc7(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_zero[idx_nxt]) seg_nxt = 7'b1111111;
`endif
        end
    end

    // seg/an are registered from the upcoming index so both switch on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= 2'd0;
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            idx <= idx_nxt;
            an  <= ~(4'b0001 << idx_nxt);
            seg <= seg_nxt;
        end
    end

`ifndef LEADING_ZERO_BLANK_EN
    logic unused_lz;
    assign unused_lz = ^lead_zero;
`endif

endmodule

// File: tb/tb_bin_to_7seg_scan.sv
// Directed self-checking bench for bin_to_7seg_scan, run with a short refresh divider.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to exercise leading-zero blanking.
module tb_bin_to_7seg_scan;

    localparam int REFRESH_DIV = 4;
    localparam int BIN_W       = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             bin_valid;
    logic [BIN_W-1:0] bin_data;
    logic             bin_ready;
    logic [15:0]      bcd_out;
    logic             overflow;
    logic [6:0]       seg;
    logic [3:0]       an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_7seg_scan #(.REFRESH_DIV(REFRESH_DIV), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_valid (bin_valid),
        .bin_data  (bin_data),
        .bin_ready (bin_ready),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .seg       (seg),
        .an        (an)
    );

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic ovf, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
        logic all_zero;
`endif
        if (ovf) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        all_zero = 1'b1;
        for (int j = idx; j < 4; j++) if (v[j*4 +: 4] != 4'd0) all_zero = 1'b0;
        if (idx > 0 && all_zero) return 7'b1111111;
`endif
        return enc(v[idx*4 +: 4]);
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Presents v for one transfer, then waits (bounded) for bin_ready to return.
    task automatic do_send(input logic [BIN_W-1:0] v, output int low, output bit tout);
        @(negedge clk);
        bin_data  = v;
        bin_valid = 1'b1;
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        low  = bin_ready ? 0 : 1;
        tout = 1'b0;
        while (!bin_ready) begin
            if (low > 40) begin
                tout = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (!bin_ready) low++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000 || bcd_out !== 16'h0000 ||
            bin_ready !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset an=%b seg=%b bcd=%h rdy=%b ovf=%b expected 1110 1000000 0000 1 0",
                     an, seg, bcd_out, bin_ready, overflow);
        end
    endtask

    task automatic test_conversion();
        int low;
        bit tout;
        int idx0;
        int ei;
        logic [3:0] prev;
        logic [3:0] ea;
        logic [6:0] es;
        bit changed;
        do_send(14'd1234, low, tout);
        checks++;
        if (tout || low != 15) begin
            errors++;
            $display("FAIL conv_latency low_cycles=%0d timeout=%0d expected 15", low, tout);
        end
        checks++;
        if (bcd_out !== 16'h1234 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL conv_value bcd=%h ovf=%b expected 1234 0", bcd_out, overflow);
        end
        @(posedge clk);
        #1;
        prev = an;
        changed = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (an != prev) begin
                changed = 1'b1;
                break;
            end
        end
        idx0 = an_idx(an);
        checks++;
        if (!changed || idx0 < 0) begin
            errors++;
            $display("FAIL conv_scan_start an=%b changed=%0d expected a one-hot-low step", an, changed);
            idx0 = 0;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ei = (idx0 + k / REFRESH_DIV) % 4;
            ea = ~(4'b0001 << ei);
            es = exp_seg(16'h1234, 1'b0, ei);
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL conv_scan k=%0d an=%b seg=%b expected an=%b seg=%b", k, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_overflow();
        int low;
        bit tout;
        int i;
        do_send(14'd10000, low, tout);
        checks++;
        if (tout || low != 15 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set ovf=%b low=%0d timeout=%0d expected 1 15 0", overflow, low, tout);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            i = an_idx(an);
            checks++;
            if (i < 0 || seg !== 7'b0111111) begin
                errors++;
                $display("FAIL ovf_dash k=%0d an=%b seg=%b expected seg=0111111", k, an, seg);
            end
        end
        do_send(14'd9999, low, tout);
        checks++;
        if (tout || overflow !== 1'b0 || bcd_out !== 16'h9999) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b bcd=%h expected 0 9999", overflow, bcd_out);
        end
    endtask

    task automatic test_handshake();
        int low;
        int i;
        logic [6:0] es;
        @(negedge clk);
        bin_data  = 14'd456;
        bin_valid = 1'b1;
        @(posedge clk);
        #1;
        bin_data = 14'd789;
        low = bin_ready ? 0 : 1;
        while (!bin_ready && low <= 40) begin
            @(posedge clk);
            #1;
            if (!bin_ready) low++;
        end
        checks++;
        if (low != 15 || bcd_out !== 16'h0456) begin
            errors++;
            $display("FAIL hs_first low=%0d bcd=%h expected 15 0456", low, bcd_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bin_ready !== 1'b0 || bcd_out !== 16'h0456) begin
            errors++;
            $display("FAIL hs_accept rdy=%b bcd=%h expected 0 0456", bin_ready, bcd_out);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            i  = an_idx(an);
            es = (i < 0) ? 7'bxxxxxxx : exp_seg(16'h0456, 1'b0, i);
            checks++;
            if (i < 0 || seg !== es || bcd_out !== 16'h0456) begin
                errors++;
                $display("FAIL hs_hold_display k=%0d an=%b seg=%b bcd=%h expected seg=%b bcd=0456",
                         k, an, seg, bcd_out, es);
            end
        end
        bin_valid = 1'b0;
        low = 0;
        while (!bin_ready && low <= 40) begin
            @(posedge clk);
            #1;
            low++;
        end
        checks++;
        if (!bin_ready || bcd_out !== 16'h0789 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hs_second rdy=%b bcd=%h ovf=%b expected 1 0789 0", bin_ready, bcd_out, overflow);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bin_data  = 14'd5678;
        bin_valid = 1'b1;
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bin_ready !== 1'b1 || bcd_out !== 16'h0000 || an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL rstmid_async rdy=%b bcd=%h an=%b seg=%b expected 1 0000 1110 1000000",
                     bin_ready, bcd_out, an, seg);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (bin_ready !== 1'b1 || bcd_out !== 16'h0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nocommit rdy=%b bcd=%h ovf=%b expected 1 0000 0", bin_ready, bcd_out, overflow);
        end
    endtask

    task automatic test_blank();
        int low;
        bit tout;
        int i;
        logic [6:0] es;
        do_send(14'd7, low, tout);
        checks++;
        if (tout || bcd_out !== 16'h0007) begin
            errors++;
            $display("FAIL blank_value bcd=%h timeout=%0d expected 0007", bcd_out, tout);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            i = an_idx(an);
            if (i == 0) es = 7'b1111000;
            else begin
`ifdef LEADING_ZERO_BLANK_EN
                es = 7'b1111111;
`else
                es = 7'b1000000;
`endif
            end
            checks++;
            if (i < 0 || seg !== es) begin
                errors++;
                $display("FAIL blank_scan k=%0d an=%b seg=%b expected %b", k, an, seg, es);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        bin_valid = 1'b0;
        bin_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_conversion();
        test_overflow();
        test_handshake();
        test_reset_mid();
        test_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_7seg_scan.md
Name: bin_to_7seg_scan

Overview:
Output end of the adder datapath: accepts the binary sum over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble (shift-add-3). It then drives one shared, time-multiplexed 7-segment bus with per-digit anode enables. Digit order is units, tens, hundreds, thousands. Sits after the adder in module_top and feeds the board display pins directly.

Parameters:
REFRESH_DIV, 6750, clk cycles per digit slot (27 MHz clk gives 4 kHz digit rate and 1 kHz frame).
BIN_W, 14, binary input width (maximum representable input 16383).

Ports:
clk  input  1  system clock, 27 MHz.
rst  input  1  reset, asynchronous, active-low.
bin_valid  input  1  bin_data valid; sender holds it until accepted.
bin_data  input  BIN_W  unsigned binary value to display.
bin_ready  output  1  high only in IDLE; a transfer occurs when bin_valid and bin_ready are both high on a rising clk edge.
bcd_out  output  16  committed BCD {thousands, hundreds, tens, units}; provided for verification.
overflow  output  1  committed value exceeds 9999.
seg  output  7  {g,f,e,d,c,b,a}, active-low (common anode).
an  output  4  one-hot active-low digit enable; an[0] is units, an[3] is thousands.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, bcd_out=16'h0000, overflow=0, digit index=0, refresh counter=0, an=4'b1110, seg=7'b1000000 (digit "0"), bin_ready=1. Reset mid-conversion aborts the conversion; no partial value is committed.
- FSM states:
  - IDLE: bin_ready=1. On a transfer, latch bin_data into the shift register, clear the BCD scratch, load iteration count BIN_W, go to CONV.
  - CONV: bin_ready=0. Each cycle, add 3 to every scratch nibble that is >=5, then shift {scratch, shift reg} left by 1. After BIN_W cycles go to COMMIT.
  - COMMIT: one cycle. Write bcd_out from the scratch. Set overflow = (latched value > 9999). Return to IDLE.
- Latency: transfer at edge N; bcd_out and overflow update at edge N+BIN_W+1 (edge N+15 at the default). bin_ready returns high on the same edge.
- bin_valid while bin_ready=0 is ignored, with no queuing.
- The display keeps showing the previous committed value during CONV.
- Overflow display: when overflow=1, every digit shows a dash, seg=7'b0111111. bcd_out holds the low 16 bits of the scratch; the bench treats it as don't-care.
- Scan: the refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an = ~(4'b0001 << index).
  - seg is the encoding of the indexed nibble.
  - seg and an are registered and change on the same edge, so there is no ghosting cycle.
- Encoding, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any nibble >9 shows blank, 1111111.
- Commit during a scan slot: the new digit value appears from the next registered seg update. The scan phase is not reset by a commit.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a zero digit is blanked (seg=7'b1111111, its an still asserted) when every higher-order digit is also zero. Units are never blanked. Overflow dashes are never blanked.
- Undefined: all four digits always display, including leading zeros.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → an=1110, seg=1000000, bcd_out=0000, bin_ready=1, overflow=0.
- Conversion: send 1234 with REFRESH_DIV=4 in the bench → bin_ready low for exactly 15 cycles, bcd_out=16'h1234. Scan sequence (an:seg) must then be 1110:0011001, 1101:0110000, 1011:0100100, 0111:1111001, repeating every 16 cycles.
- Overflow: send 10000 → overflow=1, all four digits show seg=0111111. Then send 9999 → overflow=0, bcd_out=16'h9999.
- Handshake: send 456 and hold bin_valid with 789 during CONV → 789 is not accepted until bin_ready rises. Commits are 0456 then 0789, and the display shows 0456 during the second conversion.
- Reset mid-conversion: assert rst=0 at cycle 7 of CONV for 5678 → bcd_out=0000 after release, no commit of 5678, FSM in IDLE.
- Blanking: send 7 with LEADING_ZERO_BLANK_EN defined → an=1110 slot shows 1111000, the other three slots show 1111111. Without the macro they show 1000000.
